// File: rtl/grid_pkg.sv
// Shared defaults, cell encoding, line-clear state enum and address split helpers
// for the playfield cell store.
package grid_pkg;

  localparam int CELL_W_DEF = 8;
  localparam int GRID_W_DEF = 10;
  localparam int GRID_H_DEF = 20;

  localparam logic [CELL_W_DEF-1:0] CELL_EMPTY = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } clr_state_t;

  // Addresses are packed {row,col}; these split a zero-extended address.
  function automatic int unsigned addr_row(input logic [31:0] addr, input int unsigned col_bits);
    return addr >> col_bits;
  endfunction

  function automatic int unsigned addr_col(input logic [31:0] addr, input int unsigned col_bits);
    return addr & ((32'd1 << col_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/grid_row_full_detect.sv
// Combinational full-row flag: high when every cell of the packed row is occupied.
module grid_row_full_detect
  import grid_pkg::*;
#(
  parameter int CELL_W = CELL_W_DEF,
  parameter int GRID_W = GRID_W_DEF
) (
  input  logic [GRID_W*CELL_W-1:0] row,
  output logic                     full
);

  always_comb begin
    full = 1'b1;
    for (int c = 0; c < GRID_W; c++) begin
      if (row[c*CELL_W +: CELL_W] == CELL_W'(CELL_EMPTY)) full = 1'b0;
    end
  end

endmodule

// File: rtl/grid_mem_lineclr.sv
// Playfield cell store with write-first registered read ports and a line-clear engine.
// Optional macro GRID_MEM_ROW_FLAGS_EN adds the registered row_full output.
module grid_mem_lineclr
  import grid_pkg::*;
#(
  parameter  int CELL_W   = CELL_W_DEF,
  parameter  int GRID_W   = GRID_W_DEF,
  parameter  int GRID_H   = GRID_H_DEF,
  parameter  int NUM_RD   = 2,
  localparam int COL_BITS = $clog2(GRID_W),
  localparam int ROW_BITS = $clog2(GRID_H),
  localparam int ADDR_W   = ROW_BITS + COL_BITS,
  localparam int CNT_W    = $clog2(GRID_H + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [CELL_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*CELL_W-1:0] rd_data,
  input  logic                     clr_start,
  output logic                     clr_busy,
  output logic                     clr_done,
  output logic [CNT_W-1:0]         lines_cleared
`ifdef GRID_MEM_ROW_FLAGS_EN
  ,
  output logic [GRID_H-1:0]        row_full
`endif
);

  // Flop array so a whole collapse happens in one edge.
  logic [CELL_W-1:0] mem [GRID_H][GRID_W];
  logic [GRID_H-1:0] full_c;

  clr_state_t state, state_nxt;
  logic [ROW_BITS-1:0] scan_row, scan_row_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic shift;
  logic wr_ok;

  assign wr_ok = wr_en && !clr_busy
              && (addr_row(32'(wr_addr), COL_BITS) < unsigned'(GRID_H))
              && (addr_col(32'(wr_addr), COL_BITS) < unsigned'(GRID_W));

  assign clr_busy = (state != IDLE);
  assign clr_done = (state == DONE);

  for (genvar g = 0; g < GRID_H; g++) begin : g_row
    logic [GRID_W*CELL_W-1:0] bits;
    for (genvar c = 0; c < GRID_W; c++) begin : g_col
      assign bits[c*CELL_W +: CELL_W] = mem[g][c];
    end
    grid_row_full_detect #(.CELL_W(CELL_W), .GRID_W(GRID_W)) u_det (
      .row  (bits),
      .full (full_c[g])
    );
  end

  always_comb begin
    state_nxt    = state;
    scan_row_nxt = scan_row;
    cnt_nxt      = cnt;
    shift        = 1'b0;
    case (state)
      IDLE: begin
        if (clr_start) begin
          state_nxt    = SCAN;
          scan_row_nxt = ROW_BITS'(GRID_H - 1);
          cnt_nxt      = '0;
        end
      end
      SCAN: begin
        // A collapsed row lands on scan_row, so it is re-checked next cycle.
        if (full_c[scan_row]) begin
          shift   = 1'b1;
          cnt_nxt = cnt + CNT_W'(1);
        end else if (scan_row == '0) begin
          state_nxt = DONE;
        end else begin
          scan_row_nxt = scan_row - ROW_BITS'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      scan_row      <= '0;
      cnt           <= '0;
      lines_cleared <= '0;
    end else begin
      state    <= state_nxt;
      scan_row <= scan_row_nxt;
      cnt      <= cnt_nxt;
      if (state == DONE) lines_cleared <= cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < GRID_H; r++)
        for (int c = 0; c < GRID_W; c++)
          mem[r][c] <= CELL_W'(CELL_EMPTY);
    end else if (shift) begin
      for (int k = 1; k < GRID_H; k++)
        if (ROW_BITS'(k) <= scan_row) mem[k] <= mem[k-1];
      for (int c = 0; c < GRID_W; c++)
        mem[0][c] <= CELL_W'(CELL_EMPTY);
    end else if (wr_ok) begin
      mem[wr_addr[ADDR_W-1:COL_BITS]][wr_addr[COL_BITS-1:0]] <= wr_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [CELL_W-1:0] q;
    logic              ok;
    assign a  = rd_addr[k*ADDR_W +: ADDR_W];
    assign ok = (addr_row(32'(a), COL_BITS) < unsigned'(GRID_H))
             && (addr_col(32'(a), COL_BITS) < unsigned'(GRID_W));
    always_ff @(posedge clk) begin
      if (reset || !ok)              q <= '0;
      else if (wr_ok && wr_addr == a) q <= wr_data;
      else                           q <= mem[a[ADDR_W-1:COL_BITS]][a[COL_BITS-1:0]];
    end
    assign rd_data[k*CELL_W +: CELL_W] = q;
  end

`ifdef GRID_MEM_ROW_FLAGS_EN
  always_ff @(posedge clk) begin
    if (reset) row_full <= '0;
    else       row_full <= full_c;
  end
`endif

endmodule

// File: tb/tb_grid_mem_lineclr.sv
// Self-checking bench for grid_mem_lineclr: vector table, randomized read/write and
// line-clear passes against a row-compaction reference model, plus directed corner cases.
module tb_grid_mem_lineclr;

  localparam int GH = 20;
  localparam int GW = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [17:0] rd_addr;
  logic [15:0] rd_data;
  logic        clr_start;
  logic        clr_busy;
  logic        clr_done;
  logic [4:0]  lines_cleared;
`ifdef GRID_MEM_ROW_FLAGS_EN
  logic [19:0] row_full;
`endif

  grid_mem_lineclr dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .clr_start     (clr_start),
    .clr_busy      (clr_busy),
    .clr_done      (clr_done),
    .lines_cleared (lines_cleared)
`ifdef GRID_MEM_ROW_FLAGS_EN
    ,
    .row_full      (row_full)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int model [GH][GW];

  typedef struct {
    bit    we;
    int    wr_r, wr_c, wd;
    int    r0, c0, r1, c1;
    int    e0, e1;
    string name;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] mk(input int row, input int col);
    return {row[4:0], col[3:0]};
  endfunction

  function automatic bit in_range(input int row, input int col);
    return row < GH && col < GW;
  endfunction

  function automatic bit model_row_full(input int row);
    for (int c = 0; c < GW; c++) if (model[row][c] == 0) return 1'b0;
    return 1'b1;
  endfunction

  // Reference line clear: keep non-full rows in order, pack them to the floor.
  function automatic int model_clear();
    int tmp [GH][GW];
    int dst;
    tmp = model;
    dst = GH - 1;
    for (int r = GH - 1; r >= 0; r--) begin
      bit full = 1'b1;
      for (int c = 0; c < GW; c++) if (tmp[r][c] == 0) full = 1'b0;
      if (!full) begin
        for (int c = 0; c < GW; c++) model[dst][c] = tmp[r][c];
        dst--;
      end
    end
    for (int r = dst; r >= 0; r--)
      for (int c = 0; c < GW; c++) model[r][c] = 0;
    return dst + 1;
  endfunction

  task automatic model_zero();
    for (int r = 0; r < GH; r++)
      for (int c = 0; c < GW; c++) model[r][c] = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_zero();
  endtask

  task automatic do_write(input int row, input int col, input int d);
    wr_en   = 1'b1;
    wr_addr = mk(row, col);
    wr_data = d[7:0];
    tick();
    wr_en = 1'b0;
    if (in_range(row, col)) model[row][col] = d & 255;
  endtask

  task automatic fill_row(input int row, input bit full);
    int zc;
    zc = $urandom_range(0, GW - 1);
    for (int c = 0; c < GW; c++) begin
      if (full) do_write(row, c, $urandom_range(1, 255));
      else if (c == zc) do_write(row, c, 0);
      else do_write(row, c, ($urandom_range(0, 1) == 1) ? $urandom_range(1, 255) : 0);
    end
  endtask

  task automatic dump_check(input string name);
    for (int r = 0; r < GH; r++) begin
      for (int c = 0; c < GW; c += 2) begin
        rd_addr = {mk(r, c + 1), mk(r, c)};
        tick();
        check($sformatf("%s_r%0d_c%0d", name, r, c), int'(rd_data[7:0]), model[r][c]);
        check($sformatf("%s_r%0d_c%0d", name, r, c + 1), int'(rd_data[15:8]), model[r][c + 1]);
      end
    end
  endtask

  // Start a pass, measure cycles from the start edge to clr_done, check results.
  task automatic run_pass(input string name);
    int n;
    int exp_lines;
    exp_lines = model_clear();
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    check({name, "_busy"}, int'(clr_busy), 1);
    n = 1;
    while (!clr_done && n < 100) begin
      tick();
      n++;
    end
    check({name, "_cycles"}, n, GH + exp_lines + 1);
    tick();
    check({name, "_done_pulse"}, int'(clr_done), 0);
    check({name, "_idle"}, int'(clr_busy), 0);
    check({name, "_lines"}, int'(lines_cleared), exp_lines);
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr = '0; clr_start = 1'b0;

    vecs[0] = '{1'b0, 0, 0, 8'h00, 5, 3, 5, 3, 8'h00, 8'h00, "rst_rd"};
    vecs[1] = '{1'b1, 5, 3, 8'h07, 5, 3, 0, 0, 8'h07, 8'h00, "wr_first"};
    vecs[2] = '{1'b0, 0, 0, 8'h00, 5, 3, 5, 3, 8'h07, 8'h07, "rd_back"};
    vecs[3] = '{1'b1, 2, 4, 8'hA5, 2, 4, 2, 5, 8'hA5, 8'h00, "wr_first_a5"};
    vecs[4] = '{1'b1, 20, 0, 8'hFF, 2, 4, 20, 0, 8'hA5, 8'h00, "oor_row"};
    vecs[5] = '{1'b1, 3, 12, 8'h11, 3, 12, 2, 4, 8'h00, 8'hA5, "oor_col"};
    vecs[6] = '{1'b0, 0, 0, 8'h00, 3, 2, 0, 0, 8'h00, 8'h00, "no_alias"};
    vecs[7] = '{1'b1, 19, 9, 8'h3C, 19, 9, 19, 8, 8'h3C, 8'h00, "corner"};

    do_reset();
    check("rst_busy", int'(clr_busy), 0);
    check("rst_done", int'(clr_done), 0);
    check("rst_lines", int'(lines_cleared), 0);

    foreach (vecs[i]) begin
      wr_en   = vecs[i].we;
      wr_addr = mk(vecs[i].wr_r, vecs[i].wr_c);
      wr_data = vecs[i].wd[7:0];
      rd_addr = {mk(vecs[i].r1, vecs[i].c1), mk(vecs[i].r0, vecs[i].c0)};
      tick();
      wr_en = 1'b0;
      check({vecs[i].name, "_p0"}, int'(rd_data[7:0]), vecs[i].e0);
      check({vecs[i].name, "_p1"}, int'(rd_data[15:8]), vecs[i].e1);
    end

    // Randomized read/write traffic.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      int wr_r, wr_c, wd, exp0, exp1;
      int rr [2];
      int rc [2];
      bit we;
      we   = ($urandom_range(0, 1) == 1);
      wr_r = $urandom_range(0, 21);
      wr_c = $urandom_range(0, 11);
      wd   = $urandom_range(0, 255);
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 2) == 0) begin
          rr[p] = wr_r; rc[p] = wr_c;
        end else begin
          rr[p] = $urandom_range(0, 21); rc[p] = $urandom_range(0, 11);
        end
      end
      exp0 = !in_range(rr[0], rc[0]) ? 0 :
             (we && rr[0] == wr_r && rc[0] == wr_c) ? wd : model[rr[0]][rc[0]];
      exp1 = !in_range(rr[1], rc[1]) ? 0 :
             (we && rr[1] == wr_r && rc[1] == wr_c) ? wd : model[rr[1]][rc[1]];
      wr_en   = we;
      wr_addr = mk(wr_r, wr_c);
      wr_data = wd[7:0];
      rd_addr = {mk(rr[1], rc[1]), mk(rr[0], rc[0])};
      tick();
      wr_en = 1'b0;
      if (we && in_range(wr_r, wr_c)) model[wr_r][wr_c] = wd;
      check($sformatf("rand_rw%0d_p0", i), int'(rd_data[7:0]), exp0);
      check($sformatf("rand_rw%0d_p1", i), int'(rd_data[15:8]), exp1);
    end

    // Directed: rows 19 and 17 full, marker at (16,0).
    do_reset();
    fill_row(19, 1'b1);
    fill_row(17, 1'b1);
    do_write(16, 0, 8'h01);
    run_pass("two_lines");
    check("two_lines_marker", model[18][0], 1);
    dump_check("two_lines_grid");

    // Randomized line-clear passes.
    for (int p = 0; p < 3; p++) begin
      do_reset();
      for (int r = 0; r < GH; r++) fill_row(r, $urandom_range(0, 2) == 0);
      run_pass($sformatf("rand_pass%0d", p));
      dump_check($sformatf("rand_pass%0d_grid", p));
    end

    // All rows full: worst-case pass and saturating count.
    do_reset();
    for (int r = 0; r < GH; r++) fill_row(r, 1'b1);
    run_pass("all_full");
    dump_check("all_full_grid");

    // Reset mid-scan: pass aborted with no done pulse.
    begin
      int dones;
      fill_row(19, 1'b1);
      fill_row(15, 1'b1);
      fill_row(12, 1'b0);
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      dones = 0;
      for (int i = 0; i < 5; i++) begin
        tick();
        if (clr_done) dones++;
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_zero();
      check("abort_busy", int'(clr_busy), 0);
      check("abort_done", int'(clr_done), 0);
      check("abort_lines", int'(lines_cleared), 0);
      for (int i = 0; i < 60; i++) begin
        tick();
        if (clr_done) dones++;
      end
      check("abort_no_done", dones, 0);
      dump_check("abort_grid");
    end

    // Writes and a second start while busy are dropped.
    begin
      int dones;
      do_reset();
      fill_row(19, 1'b1);
      fill_row(18, 1'b1);
      fill_row(10, 1'b0);
      void'(model_clear());
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      dones = 0;
      tick();
      tick();
      wr_en = 1'b1; wr_addr = mk(0, 0); wr_data = 8'h55; clr_start = 1'b1;
      tick();
      wr_en = 1'b0; clr_start = 1'b0;
      for (int i = 0; i < 80; i++) begin
        if (clr_done) dones++;
        tick();
      end
      check("busy_one_done", dones, 1);
      check("busy_lines", int'(lines_cleared), 2);
      dump_check("busy_grid");
    end

`ifdef GRID_MEM_ROW_FLAGS_EN
    do_reset();
    for (int c = 0; c < GW; c++) do_write(10, c, c + 1);
    check("flag_pre", int'(row_full[10]), 0);
    tick();
    check("flag_row10", int'(row_full[10]), 1);
    check("flag_others", int'(row_full & ~20'(1 << 10)), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
